// File: rtl/delay_timer_bank.sv
// delay_timer_bank: bank of independent prescaled delay timers, one-shot or auto-reload per channel
module delay_timer_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 12,
  parameter int PRESCALE = 50000,
  parameter int PRE_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*CNT_W-1:0] cycles,
  input  logic [CHANNELS-1:0]       periodic,
  output logic [CHANNELS-1:0]       go,
  output logic [CHANNELS-1:0]       done_pulse,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  logic [CHANNELS-1:0] counting;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, cyc;
    logic [PRE_W-1:0] pre, pre_n;
    logic             go_q, go_n, pulse_q, pulse_n, tick;
    assign cyc  = cycles[c*CNT_W +: CNT_W];
    assign tick = pre == PRE_MAX;
    always_comb begin
      st_n    = st;
      cnt_n   = cnt;
      pre_n   = pre;
      go_n    = go_q;
      pulse_n = 1'b0;
      if (!enable[c]) begin
        st_n  = IDLE;
        cnt_n = '0;
        pre_n = '0;
        go_n  = 1'b0;
      end else if (st == IDLE) begin
        st_n  = COUNT;
        cnt_n = cyc;
        pre_n = '0;
        go_n  = 1'b0;
      end else if (st == COUNT) begin
        pre_n = tick ? '0 : pre + 1'b1;
        if (tick && cnt != '0) cnt_n = cnt - 1'b1;
        // expiry: periodic reloads in place, one-shot latches go until enable drops
        if (tick && cnt == '0) begin
          pulse_n = 1'b1;
          cnt_n   = periodic[c] ? cyc : cnt;
          st_n    = periodic[c] ? COUNT : DONE;
          go_n    = !periodic[c];
        end
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st      <= IDLE;
        cnt     <= '0;
        pre     <= '0;
        go_q    <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        st      <= st_n;
        cnt     <= cnt_n;
        pre     <= pre_n;
        go_q    <= go_n;
        pulse_q <= pulse_n;
      end
    end
    assign go[c]         = go_q;
    assign done_pulse[c] = pulse_q;
    assign counting[c]   = st == COUNT;
  end
  assign busy = |counting;
endmodule

// File: tb/tb_delay_timer_bank.sv
// tb_delay_timer_bank: randomized check of delay_timer_bank against a deadline-based reference model
module tb_delay_timer_bank;
  localparam int CH = 2, CW = 4, P = 4;
  logic clk = 0, rst_n = 1;
  logic [CH-1:0] enable = '0, periodic = '0;
  logic [CH*CW-1:0] cycles = '0;
  logic [CH-1:0] go, done_pulse;
  logic busy;
  int tests = 0, fails = 0, edge_n = 0;
  int m_st[CH];
  int dl[CH];
  logic [CH-1:0] m_go, m_pl;

  always #5 clk = ~clk;

  delay_timer_bank #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(P), .PRE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cycles(cycles),
    .periodic(periodic), .go(go), .done_pulse(done_pulse), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", tag, got, exp, edge_n, $time);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < CH; i++) m_st[i] = 0;
    m_go = '0;
    m_pl = '0;
  endtask

  // states: 0 idle, 1 counting toward deadline dl, 2 done
  task automatic step;
    int b;
    @(posedge clk);
    edge_n++;
    if (rst_n) for (int i = 0; i < CH; i++) begin
      int c;
      c = int'(cycles[i*CW +: CW]);
      m_pl[i] = 1'b0;
      if (!enable[i]) begin
        m_st[i] = 0;
        m_go[i] = 1'b0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1;
        dl[i] = edge_n + (c + 1) * P;
      end else if (m_st[i] == 1 && edge_n == dl[i]) begin
        m_pl[i] = 1'b1;
        if (periodic[i]) dl[i] = edge_n + (c + 1) * P;
        else begin
          m_st[i] = 2;
          m_go[i] = 1'b1;
        end
      end
    end
    #1;
    b = 0;
    for (int i = 0; i < CH; i++) if (m_st[i] == 1) b = 1;
    chk("go", 32'(go), 32'(m_go));
    chk("done_pulse", 32'(done_pulse), 32'(m_pl));
    chk("busy", 32'(busy), 32'(b));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_go", 32'(go), 0);
    chk("rst_done", 32'(done_pulse), 0);
    chk("rst_busy", 32'(busy), 0);
    run(n);
    rst_n = 1'b1;
  endtask

  task automatic set_cyc(input int ch, input int v);
    cycles[ch*CW +: CW] = CW'(v);
  endtask

  initial begin
    int k0, hit;
    model_reset();
    #2;
    do_reset(3);
    // one-shot latency and go hold
    set_cyc(0, 3);
    enable[0] = 1'b1;
    k0 = edge_n + 1;
    hit = -1;
    for (int j = 0; j < 40 && hit < 0; j++) begin
      step();
      if (done_pulse[0]) hit = edge_n;
    end
    chk("t1_latency", 32'(hit - k0), 16);
    run(6);
    enable[0] = 1'b0;
    run(3);
    // periodic reload
    set_cyc(1, 1);
    periodic[1] = 1'b1;
    enable[1] = 1'b1;
    run(30);
    enable[1] = 1'b0;
    periodic[1] = 1'b0;
    run(2);
    // boundary counts
    set_cyc(0, 0);
    enable[0] = 1'b1;
    run(6);
    enable[0] = 1'b0;
    run(1);
    set_cyc(0, 15);
    enable[0] = 1'b1;
    run(70);
    enable[0] = 1'b0;
    run(1);
    // abandon mid-count then restart
    set_cyc(0, 3);
    enable[0] = 1'b1;
    run(10);
    enable[0] = 1'b0;
    run(3);
    enable[0] = 1'b1;
    run(20);
    enable[0] = 1'b0;
    run(1);
    // cycles change mid-count is ignored until reload
    periodic[0] = 1'b1;
    enable[0] = 1'b1;
    run(5);
    set_cyc(0, 1);
    run(25);
    enable[0] = 1'b0;
    periodic[0] = 1'b0;
    run(1);
    // async reset mid-count on both channels
    set_cyc(0, 5);
    set_cyc(1, 2);
    enable = '1;
    run(7);
    do_reset(2);
    run(30);
    enable = '0;
    run(1);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 19) == 0) enable[i] = ~enable[i];
        if ($urandom_range(0, 9) == 0)
          set_cyc(i, ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4)));
        if ($urandom_range(0, 29) == 0) periodic[i] = ~periodic[i];
      end
      if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
      else step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
